uart_sample_buffer: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its byte stream (data, valid pulse, framing error).
- Packs little-endian bytes into sampleBits-wide audio samples and resynchronises on inter-frame gaps.
- Buffers samples in a FIFO and releases one per sampleStrobe from the sample-rate generator feeding the FM modulator.
- Flags overflow, underflow and sync/data errors for the test harness.

---
 rtl/uart_sample_pkg.sv | 31 +++
 rtl/uart_sample_buffer_if.sv | 28 ++
 rtl/sample_fifo.sv | 44 ++++
 rtl/uart_sample_buffer.sv | 136 +++++++++++++
 tb/tb_uart_sample_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sample_pkg.sv
// rtl/uart_sample_pkg.sv - shared constants, sizing helpers and assembler state encoding
package uart_sample_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } asm_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sample_bytes(input int sample_bits);
        return sample_bits / 8;
    endfunction

    // Idle time of gap_bytes UART frames (10 bits each) expressed in clock cycles
    function automatic int gap_cycles(input longint clock_rate, input longint baud_rate,
                                      input int gap_bytes);
        return int'(longint'(gap_bytes) * 64'd10 * clock_rate / baud_rate);
    endfunction

    localparam int SAMPLE_BYTES = sample_bytes(16);
    localparam int GAP_CYCLES   = gap_cycles(60_000_000, 12_000_000, 2);

endpackage

// File: rtl/uart_sample_buffer_if.sv
// rtl/uart_sample_buffer_if.sv - byte stream in, sample stream and status out
interface uart_sample_buffer_if #(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_BITS   = 10
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_error;
    logic                   sample_strobe;
    logic                   clear_errors;
    logic [SAMPLE_BITS-1:0] sample;
    logic                   sample_valid;
    logic [FIFO_BITS:0]     level;
    logic                   overflow;
    logic                   underflow;
    logic                   sync_error;
    logic                   data_error;

    modport master (
        output rx_data, rx_valid, rx_error, sample_strobe, clear_errors,
        input  sample, sample_valid, level, overflow, underflow, sync_error, data_error
    );

    modport slave (
        input  rx_data, rx_valid, rx_error, sample_strobe, clear_errors,
        output sample, sample_valid, level, overflow, underflow, sync_error, data_error
    );
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock FIFO with registered read port and occupancy count
module sample_fifo #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the addresses match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage and read register carry no reset so they can map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_BITS-1:0]] <= wr_data;
        if (rd_en) rd_data <= mem[rd_ptr[ADDR_BITS-1:0]];
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

endmodule

// File: rtl/uart_sample_buffer.sv
// rtl/uart_sample_buffer.sv - packs UART bytes into samples, buffers them, releases one per strobe
module uart_sample_buffer
    import uart_sample_pkg::*;
#(
    parameter int CLOCK_RATE  = 60_000_000,
    parameter int BAUD_RATE   = 12_000_000,
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_BITS   = 10,
    parameter int GAP_BYTES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_sample_buffer_if.slave  bus
);
    localparam int SB    = sample_bytes(SAMPLE_BITS);
    localparam int GAP   = gap_cycles(CLOCK_RATE, BAUD_RATE, GAP_BYTES);
    localparam int IDX_W = (SB > 1) ? clog2(SB) : 1;
    localparam int GAP_W = clog2(GAP + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SB - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    asm_state_t             state;
    logic [IDX_W-1:0]       idx;
    logic [SAMPLE_BITS-1:0] asm_word;
    logic [SAMPLE_BITS-1:0] merged;
    logic [GAP_W-1:0]       gap_cnt;

    logic                   byte_ok;
    logic                   last_byte;
    logic                   timeout;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_BITS:0]     fifo_level;
    logic [SAMPLE_BITS-1:0] fifo_rd_data;
    logic                   wr_en;
    logic                   rd_en;
    logic                   ovf_evt;
    logic                   udf_evt;

    logic                   loaded;
    logic                   sample_valid_q;
    logic                   overflow_q;
    logic                   underflow_q;
    logic                   sync_error_q;
    logic                   data_error_q;

    assign byte_ok   = bus.rx_valid & ~bus.rx_error;
    assign last_byte = byte_ok & (idx == LAST_IDX);
    // Timeout fires on the cycle the idle count reaches GAP while a sample is half built
    assign timeout   = ~bus.rx_valid & (gap_cnt == GAP_LAST) & (state == ST_COLLECT);

    always_comb begin
        merged = asm_word;
        merged[8*idx +: 8] = bus.rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            asm_word <= '0;
            gap_cnt  <= '0;
        end else begin
            if (bus.rx_valid)          gap_cnt <= '0;
            else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;

            if (bus.rx_error || timeout) begin
                state    <= ST_IDLE;
                idx      <= '0;
                asm_word <= '0;
            end else if (bus.rx_valid) begin
                if (idx == LAST_IDX) begin
                    state    <= ST_IDLE;
                    idx      <= '0;
                    asm_word <= '0;
                end else begin
                    state    <= ST_COLLECT;
                    idx      <= idx + 1'b1;
                    asm_word <= merged;
                end
            end
        end
    end

    // Read decision uses pre-write occupancy, so there is no write-to-read bypass
    assign rd_en   = bus.sample_strobe & ~fifo_empty;
    assign udf_evt = bus.sample_strobe & fifo_empty;
    assign wr_en   = last_byte & (~fifo_full | rd_en);
    assign ovf_evt = last_byte & fifo_full & ~rd_en;

    sample_fifo #(
        .WIDTH     (SAMPLE_BITS),
        .ADDR_BITS (FIFO_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (merged),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded         <= 1'b0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            sync_error_q   <= 1'b0;
            data_error_q   <= 1'b0;
        end else begin
            loaded         <= loaded | rd_en;
            sample_valid_q <= rd_en;
            overflow_q     <= (overflow_q   & ~bus.clear_errors) | ovf_evt;
            underflow_q    <= (underflow_q  & ~bus.clear_errors) | udf_evt;
            sync_error_q   <= (sync_error_q & ~bus.clear_errors) | timeout;
            data_error_q   <= (data_error_q & ~bus.clear_errors) | bus.rx_error;
        end
    end

    // Read register is unreset RAM output; mask it until the first pop after reset
    assign bus.sample       = loaded ? fifo_rd_data : '0;
    assign bus.sample_valid = sample_valid_q;
    assign bus.level        = fifo_level;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.sync_error   = sync_error_q;
    assign bus.data_error   = data_error_q;

endmodule

// File: tb/tb_uart_sample_buffer.sv
// tb/tb_uart_sample_buffer.sv - directed and random checks of uart_sample_buffer against a queue model
module tb_uart_sample_buffer;
    localparam int SB    = 2;
    localparam int GAP   = 100;
    localparam int DEPTH = 1024;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    uart_sample_buffer_if #(.SAMPLE_BITS(16), .FIFO_BITS(10)) bus ();

    uart_sample_buffer #(
        .CLOCK_RATE  (60_000_000),
        .BAUD_RATE   (12_000_000),
        .SAMPLE_BITS (16),
        .FIFO_BITS   (10),
        .GAP_BYTES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  pq[$];
    logic [15:0] mq[$];
    int          idle_cnt;
    logic [15:0] m_sample;
    bit          m_valid, m_ovf, m_udf, m_sync, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        mq.delete();
        idle_cnt = 0;
        m_sample = '0;
        m_valid = 0; m_ovf = 0; m_udf = 0; m_sync = 0; m_data = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit e, input bit s, input bit c);
        int pre;
        bit rd, tmo, complete, ov, ud;
        logic [15:0] w;
        pre = mq.size();
        rd = s && (pre > 0);
        ud = s && (pre == 0);
        complete = 0;
        ov = 0;
        w = '0;
        if (v) idle_cnt = 0; else idle_cnt++;
        tmo = !v && (idle_cnt == GAP) && (pq.size() > 0);
        if (e || tmo) begin
            pq.delete();
        end else if (v) begin
            pq.push_back(d);
            if (pq.size() == SB) begin
                for (int i = 0; i < SB; i++) w[8*i +: 8] = pq[i];
                complete = 1;
                pq.delete();
            end
        end
        m_valid = rd;
        if (rd) m_sample = mq.pop_front();
        if (complete) begin
            if (pre == DEPTH && !rd) ov = 1;
            else mq.push_back(w);
        end
        m_ovf  = (m_ovf  && !c) || ov;
        m_udf  = (m_udf  && !c) || ud;
        m_sync = (m_sync && !c) || tmo;
        m_data = (m_data && !c) || e;
    endtask

    task automatic check_outputs();
        chk("sample",       32'(bus.sample),       32'(m_sample));
        chk("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
        chk("level",        32'(bus.level),        32'(mq.size()));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_udf));
        chk("sync_error",   32'(bus.sync_error),   32'(m_sync));
        chk("data_error",   32'(bus.data_error),   32'(m_data));
    endtask

    task automatic drive_idle_inputs();
        bus.rx_valid = 0; bus.rx_data = '0; bus.rx_error = 0;
        bus.sample_strobe = 0; bus.clear_errors = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit e, input bit s, input bit c);
        bus.rx_valid = v; bus.rx_data = d; bus.rx_error = e;
        bus.sample_strobe = s; bus.clear_errors = c;
        @(posedge clk);
        model_edge(v, d, e, s, c);
        #1;
        check_outputs();
        drive_idle_inputs();
    endtask

    task automatic send(input logic [7:0] b); step(1, b, 0, 0, 0); endtask
    task automatic strobe(); step(0, 8'h00, 0, 1, 0); endtask
    task automatic clear(); step(0, 8'h00, 0, 0, 1); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sample"}, 32'(bus.sample), 32'h0);
        chk({tag, "_valid"},  32'(bus.sample_valid), 32'h0);
        chk({tag, "_level"},  32'(bus.level), 32'h0);
        chk({tag, "_flags"},  32'({bus.overflow, bus.underflow, bus.sync_error, bus.data_error}), 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive_idle_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Basic two-byte sample and one strobe
        send(8'h34); idle(10); send(8'h12);
        chk("t1_level", 32'(bus.level), 32'd1);
        strobe();
        chk("t1_sample", 32'(bus.sample), 32'h1234);
        chk("t1_valid", 32'(bus.sample_valid), 32'd1);
        chk("t1_level0", 32'(bus.level), 32'd0);
        idle(1);
        chk("t1_valid_pulse", 32'(bus.sample_valid), 32'd0);

        // Gap exactly one cycle short of the timeout keeps the partial sample
        send(8'hCC); idle(GAP - 1); send(8'hDD); strobe();
        chk("gap99_sample", 32'(bus.sample), 32'hDDCC);
        chk("gap99_sync", 32'(bus.sync_error), 32'd0);

        // Gap timeout discards the partial sample
        send(8'hAA); idle(GAP);
        chk("gap_sync", 32'(bus.sync_error), 32'd1);
        send(8'h78); send(8'h56); strobe();
        chk("gap_sample", 32'(bus.sample), 32'h5678);
        chk("gap_level", 32'(bus.level), 32'd0);
        clear();
        chk("gap_clear", 32'(bus.sync_error), 32'd0);

        // rxError discards partial; coincident byte is discarded too
        send(8'h11); step(0, 8'h00, 1, 0, 0); send(8'h22); send(8'h33); strobe();
        chk("err_flag", 32'(bus.data_error), 32'd1);
        chk("err_sample", 32'(bus.sample), 32'h3322);
        send(8'h44); step(1, 8'h55, 1, 0, 0); send(8'h66); send(8'h77); strobe();
        chk("err_coinc_sample", 32'(bus.sample), 32'h7766);
        // Clear and a new error event in the same cycle: the event wins
        step(0, 8'h00, 1, 0, 1);
        chk("err_clear_wins", 32'(bus.data_error), 32'd1);
        clear();
        chk("err_cleared", 32'(bus.data_error), 32'd0);

        // Underflow holds the last sample; clear drops the flag
        send(8'hEF); send(8'hBE); strobe();
        chk("udf_pre", 32'(bus.sample), 32'hBEEF);
        strobe();
        chk("udf_flag", 32'(bus.underflow), 32'd1);
        chk("udf_hold", 32'(bus.sample), 32'hBEEF);
        chk("udf_novalid", 32'(bus.sample_valid), 32'd0);
        clear();
        chk("udf_clear", 32'(bus.underflow), 32'd0);

        // Write and strobe together on an empty FIFO: underflow, sample stays queued
        send(8'h01); step(1, 8'h02, 0, 1, 0);
        chk("nobypass_udf", 32'(bus.underflow), 32'd1);
        chk("nobypass_level", 32'(bus.level), 32'd1);
        strobe();
        chk("nobypass_sample", 32'(bus.sample), 32'h0201);
        clear();

        // Fill to full, overflow one, then full+read keeps level
        for (int i = 0; i < DEPTH; i++) begin
            send(8'($urandom)); send(8'($urandom));
        end
        chk("full_level", 32'(bus.level), 32'd1024);
        chk("full_noovf", 32'(bus.overflow), 32'd0);
        send(8'h99); send(8'h88);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level), 32'd1024);
        send(8'h5A); step(1, 8'hA5, 0, 1, 0);
        chk("full_rdwr_level", 32'(bus.level), 32'd1024);
        for (int i = 0; i < DEPTH; i++) strobe();
        chk("drain_tail", 32'(bus.sample), 32'hA55A);
        chk("drain_level", 32'(bus.level), 32'd0);
        strobe();
        chk("drain_udf", 32'(bus.underflow), 32'd1);
        clear();

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                if ($urandom_range(0, 1) == 1) send(8'($urandom));
                idle(int'($urandom_range(GAP - 5, GAP + 30)));
            end else begin
                step(($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5));
            end
        end

        // Async reset mid-sample with level 5
        while (mq.size() > 0) strobe();
        clear();
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom)); send(8'($urandom));
        end
        send(8'hF0);
        chk("prereset_level", 32'(bus.level), 32'd5);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'hCD); send(8'hAB);
        chk("postreset_level", 32'(bus.level), 32'd1);
        strobe();
        chk("postreset_sample", 32'(bus.sample), 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
